// File: rtl/wallace_mult_pipe.sv
// wallace_mult_pipe: three-stage pipelined Baugh-Wooley / Wallace-tree multiplier with valid/ready flow control
module wallace_mult_pipe #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod,
  output logic               busy
);
  localparam int PW = 2*WIDTH;
  localparam int NR = WIDTH + 1;
  localparam logic [PW-1:0] BW_K = (PW'(1) << WIDTH) | (PW'(1) << (PW-1));
  logic             w_stall;
  logic [WIDTH-1:0] r_a, r_b;
  logic             r_sg, r_v1, r_v2, r_v3;
  logic [PW-1:0]    r_sum, r_car, r_prod, w_sum, w_car;
  logic [PW-1:0]    w_pp [NR];
  assign w_stall   = r_v3 & ~out_ready;
  assign in_ready  = ~w_stall;
  assign out_valid = r_v3;
  assign out_prod  = r_prod;
  assign busy      = r_v1 | r_v2 | r_v3;
  // partial-product rows; in signed mode terms pairing exactly one sign bit are inverted and the correction row is added
  always_comb begin
    for (int j = 0; j < WIDTH; j++) begin
      w_pp[j] = '0;
      for (int i = 0; i < WIDTH; i++)
        w_pp[j][i+j] = (r_a[i] & r_b[j]) ^ (r_sg & ((i == WIDTH-1) != (j == WIDTH-1)));
    end
    w_pp[WIDTH] = r_sg ? BW_K : '0;
  end
  // Wallace reduction: each layer compresses row triples with full adders until two rows remain
  always_comb begin
    logic [PW-1:0] t  [NR];
    logic [PW-1:0] nx [NR];
    int n, m;
    for (int k = 0; k < NR; k++) t[k] = w_pp[k];
    n = NR;
    for (int l = 0; l < NR; l++) begin
      for (int k = 0; k < NR; k++) nx[k] = '0;
      m = 0;
      for (int g = 0; g <= NR/3; g++)
        if (3*g+2 < n) begin
          nx[m]   = t[3*g] ^ t[3*g+1] ^ t[3*g+2];
          nx[m+1] = ((t[3*g] & t[3*g+1]) | (t[3*g] & t[3*g+2]) | (t[3*g+1] & t[3*g+2])) << 1;
          m += 2;
        end else if (3*g < n) begin
          nx[m]   = t[3*g];
          nx[m+1] = (3*g+1 < n) ? t[3*g+1] : '0;
          m += (3*g+1 < n) ? 2 : 1;
        end
      if (n > 2) begin
        for (int k = 0; k < NR; k++) t[k] = nx[k];
        n = m;
      end
    end
    w_sum = t[0];
    w_car = t[1];
  end
  // S1: operand register
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_a  <= '0;
      r_b  <= '0;
      r_sg <= 1'b0;
      r_v1 <= 1'b0;
    end else if (!w_stall) begin
      r_a  <= in_a;
      r_b  <= in_b;
      r_sg <= in_signed;
      r_v1 <= in_valid & in_ready;
    end
  // S2: carry-save result of the reduction tree
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_sum <= '0;
      r_car <= '0;
      r_v2  <= 1'b0;
    end else if (!w_stall) begin
      r_sum <= w_sum;
      r_car <= w_car;
      r_v2  <= r_v1;
    end
  // S3: carry-propagate add into the output register
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_prod <= '0;
      r_v3   <= 1'b0;
    end else if (!w_stall) begin
      r_prod <= r_sum + r_car;
      r_v3   <= r_v2;
    end
endmodule
